match_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares one vocabulary matcher between `NUM_REQ` requesters. It accepts lookup requests, forwards the granted word to the matcher, and pulses the matcher's `cs`. It then waits for `done` and returns `found` and the match address to the owning requester. Between lookups it pulses the matcher's reset, because the matcher holds `done` until reset. The block sits between the tokenizer front-end ports and the single matcher/vocab SRAM instance.

---
 rtl/match_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_match_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_scheduler.sv
// match_scheduler
//   Shares one vocabulary matcher between NUM_REQ requesters. A round-robin
//   arbiter picks a requester, the latched word is sent to the matcher with a
//   one-cycle cs pulse, and the result returns to the owner. The matcher keeps
//   done high until it is reset, so it gets a one-cycle reset pulse after
//   every lookup.
//
//   Optional macro MATCH_SCHED_TIMEOUT_EN adds a watchdog. If the matcher does
//   not answer within TIMEOUT_CYCLES WAIT cycles, the lookup is aborted with
//   rsp_err=1.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   req          per-requester level request
//   req_word     per-requester word, slice i belongs to requester i
//   gnt          one-hot acceptance pulse
//   rsp_valid    one-hot result pulse to the owner
//   rsp_found    word present (held until next result)
//   rsp_addr     matcher address at completion (held)
//   rsp_err      lookup aborted by the watchdog (held)
//   busy         high whenever a lookup is in flight
//   mch_rst_n    registered reset to the matcher
//   mch_cs       matcher start pulse
//   mch_word     latched word to the matcher
//   mch_done     matcher done, sticky until matcher reset
//   mch_found    matcher found flag
//   mch_addr     matcher final address
//
// state | meaning
// IDLE  | matcher out of reset, arbitrating among requests
// ISSUE | grant issued, starting the matcher
// WAIT  | waiting for done (and watchdog, when enabled)
// RESP  | result pulse to the owner, matcher held in reset
module match_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int WORD_LENGTH    = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ*WORD_LENGTH*DATA_WIDTH-1:0] req_word,
  output logic [NUM_REQ-1:0]                       gnt,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  output logic                                     rsp_found,
  output logic [ADDR_WIDTH-1:0]                    rsp_addr,
  output logic                                     rsp_err,
  output logic                                     busy,
  output logic                                     mch_rst_n,
  output logic                                     mch_cs,
  output logic [WORD_LENGTH*DATA_WIDTH-1:0]        mch_word,
  input  logic                                     mch_done,
  input  logic                                     mch_found,
  input  logic [ADDR_WIDTH-1:0]                    mch_addr
);

  localparam int WW   = WORD_LENGTH * DATA_WIDTH;
  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_n;
  logic [IDXW-1:0]     last, last_n;
  logic [IDXW-1:0]     owner, owner_n;
  logic [NUM_REQ-1:0]  gnt_n, rsp_valid_n;
  logic                rsp_found_n, busy_n, mch_rst_n_n, mch_cs_n;
  logic [ADDR_WIDTH-1:0] rsp_addr_n;
  logic [WW-1:0]       mch_word_n;

  logic                pick_valid;
  logic [IDXW-1:0]     pick;

`ifdef MATCH_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            rsp_err_n;
`endif

  // Round-robin search starting just after the last owner.
  always_comb begin
    int j;
    logic [IDXW-1:0] cand;
    pick_valid = 1'b0;
    pick       = '0;
    j          = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j    = (int'(last) + k) % NUM_REQ;
      cand = IDXW'(j);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    last_n      = last;
    owner_n     = owner;
    gnt_n       = '0;
    rsp_valid_n = '0;
    rsp_found_n = rsp_found;
    rsp_addr_n  = rsp_addr;
    mch_cs_n    = 1'b0;
    mch_word_n  = mch_word;
    mch_rst_n_n = 1'b1;
`ifdef MATCH_SCHED_TIMEOUT_EN
    wd_cnt_n    = wd_cnt;
    rsp_err_n   = rsp_err;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_n      = NUM_REQ'(1) << pick;
          mch_word_n = req_word[int'(pick)*WW +: WW];
          owner_n    = pick;
          last_n     = pick;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        mch_cs_n = 1'b1;
        state_n  = WAIT;
`ifdef MATCH_SCHED_TIMEOUT_EN
        wd_cnt_n = '0;
`endif
      end
      WAIT: begin
        // The cycle in which cs is visible to the matcher is not part of the
        // wait window; done cannot legitimately be a response yet.
        if (!mch_cs) begin
          if (mch_done) begin
            rsp_found_n = mch_found;
            rsp_addr_n  = mch_addr;
            rsp_valid_n = NUM_REQ'(1) << owner;
            mch_rst_n_n = 1'b0;
            state_n     = RESP;
`ifdef MATCH_SCHED_TIMEOUT_EN
            rsp_err_n   = 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            rsp_err_n   = 1'b1;
            rsp_found_n = 1'b0;
            rsp_addr_n  = '0;
            rsp_valid_n = NUM_REQ'(1) << owner;
            mch_rst_n_n = 1'b0;
            state_n     = RESP;
          end else begin
            wd_cnt_n    = wd_cnt + 1'b1;
`endif
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDXW'(NUM_REQ - 1);
      owner     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_found <= 1'b0;
      rsp_addr  <= '0;
      busy      <= 1'b0;
      mch_rst_n <= 1'b0;
      mch_cs    <= 1'b0;
      mch_word  <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      owner     <= owner_n;
      gnt       <= gnt_n;
      rsp_valid <= rsp_valid_n;
      rsp_found <= rsp_found_n;
      rsp_addr  <= rsp_addr_n;
      busy      <= busy_n;
      mch_rst_n <= mch_rst_n_n;
      mch_cs    <= mch_cs_n;
      mch_word  <= mch_word_n;
    end
  end

`ifdef MATCH_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      wd_cnt  <= wd_cnt_n;
      rsp_err <= rsp_err_n;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_match_scheduler.sv
module tb_match_scheduler;
  localparam int NR = 4;
  localparam int WL = 3;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 64;
  localparam int WW = WL * DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*WW-1:0]  req_word;
  logic [NR-1:0]     gnt, rsp_valid;
  logic              rsp_found, rsp_err, busy, mch_rst_n, mch_cs;
  logic [AW-1:0]     rsp_addr;
  logic [WW-1:0]     mch_word;
  logic              mch_done, mch_found;
  logic [AW-1:0]     mch_addr;

  typedef struct {
    int            owner;
    logic [WW-1:0] word;
    logic          found;
    logic [AW-1:0] addr;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   mdl_lat  = 6;

  match_scheduler #(
    .NUM_REQ(NR), .WORD_LENGTH(WL), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_word(req_word),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_found(rsp_found),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .busy(busy),
    .mch_rst_n(mch_rst_n), .mch_cs(mch_cs), .mch_word(mch_word),
    .mch_done(mch_done), .mch_found(mch_found), .mch_addr(mch_addr)
  );

  always #5 clk = ~clk;

  // Vocabulary rule of the matcher model: a word whose first symbol is zero is
  // absent; the address is the low nibble plus one.
  function automatic logic [AW:0] vocab(input logic [WW-1:0] w);
    logic [3:0] a;
    a = w[3:0] + 4'd1;
    return {(w[23:16] != 8'h00), a};
  endfunction

  // Matcher model: done rises mdl_lat cycles after cs (never if mdl_lat==0),
  // sticky until its reset.
  logic [WW-1:0] m_word;
  int            m_cnt;
  logic          m_armed;
  always @(negedge clk) begin
    if (!mch_rst_n) begin
      mch_done  <= 1'b0;
      mch_found <= 1'b0;
      mch_addr  <= '0;
      m_armed   <= 1'b0;
      m_cnt     <= 0;
    end else if (mch_cs) begin
      m_word  <= mch_word;
      m_cnt   <= mdl_lat;
      m_armed <= (mdl_lat != 0);
    end else if (m_armed) begin
      if (m_cnt == 1) begin
        mch_done               <= 1'b1;
        {mch_found, mch_addr}  <= vocab(m_word);
        m_armed                <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int o, input logic [WW-1:0] w);
    exp_t e;
    e.owner = o;
    e.word  = w;
    {e.found, e.addr} = vocab(w);
    e.err   = 1'b0;
    sb.push_back(e);
  endtask

  task automatic set_word(input int i, input logic [WW-1:0] w);
    req_word[i*WW +: WW] = w;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"},   32'(gnt), 0);
    chk({tag, "_rspv"},  32'(rsp_valid), 0);
    chk({tag, "_found"}, 32'(rsp_found), 0);
    chk({tag, "_addr"},  32'(rsp_addr), 0);
    chk({tag, "_err"},   32'(rsp_err), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_cs"},    32'(mch_cs), 0);
    chk({tag, "_word"},  32'(mch_word), 0);
    chk({tag, "_mrst"},  32'(mch_rst_n), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Waits for a grant, checks it against the head of the scoreboard, then
  // checks the cs cycle. Returns #1 after the cs edge.
  task automatic do_issue();
    int n;
    n = 0;
    while (gnt == '0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gnt_seen", 32'(gnt != '0), 1);
    if (sb.size() > 0) begin
      chk("gnt_owner", 32'(gnt), 32'(1) << sb[0].owner);
      chk("busy_at_gnt", 32'(busy), 1);
      chk("cs_low_at_gnt", 32'(mch_cs), 0);
      @(posedge clk); #1;
      chk("cs_pulse", 32'(mch_cs), 1);
      chk("gnt_one_cycle", 32'(gnt), 0);
      chk("mch_word", 32'(mch_word), 32'(sb[0].word));
    end
  endtask

  // Called #1 after the cs edge; exp_lat is cycles from cs to rsp_valid.
  task automatic wait_rsp(input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rsp_valid == '0 && n < 300);
    chk("rsp_seen", 32'(rsp_valid != '0), 1);
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_latency", n, exp_lat);
        chk("rsp_valid_owner", 32'(rsp_valid), 32'(1) << e.owner);
        chk("rsp_found", 32'(rsp_found), 32'(e.found));
        chk("rsp_addr", 32'(rsp_addr), 32'(e.addr));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("mch_rst_pulse", 32'(mch_rst_n), 0);
        chk("busy_at_rsp", 32'(busy), 1);
        @(posedge clk); #1;
        chk("rsp_one_cycle", 32'(rsp_valid), 0);
        chk("mch_rst_release", 32'(mch_rst_n), 1);
        chk("busy_idle", 32'(busy), 0);
        chk("rsp_found_hold", 32'(rsp_found), 32'(e.found));
        chk("rsp_addr_hold", 32'(rsp_addr), 32'(e.addr));
      end
    end
  endtask

  initial begin
    int   cnt;
    exp_t e;
    rst_n    = 1'b0;
    req      = '0;
    req_word = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_after_reset", 32'(mch_rst_n), 1);

    // 1: single lookup, found
    mdl_lat = 6;
    set_word(0, 24'h636174);
    push(0, 24'h636174);
    req = 4'b0001;
    do_issue();
    req = '0;
    wait_rsp(7);

    // 2: all requesting from reset, grants 0,1,2,3
    do_reset();
    mdl_lat = 2;
    set_word(0, 24'h616201);
    set_word(1, 24'h626202);
    set_word(2, 24'h63630E);
    set_word(3, 24'h00640F);
    for (int i = 0; i < NR; i++) push(i, req_word[i*WW +: WW]);
    req = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      do_issue();
      req[i] = 1'b0;
      wait_rsp(3);
    end

    // 3: fairness, last grant 1 with 1 and 3 held high
    mdl_lat = 3;
    set_word(1, 24'h6F6E03);
    set_word(3, 24'h747705);
    push(1, 24'h6F6E03);
    req = 4'b0010;
    do_issue();
    req = 4'b1010;
    push(3, 24'h747705);
    push(1, 24'h6F6E03);
    wait_rsp(4);
    do_issue();
    wait_rsp(4);
    do_issue();
    req = '0;
    wait_rsp(4);

    // 4: not found
    mdl_lat = 4;
    set_word(0, 24'h00787E);
    push(0, 24'h00787E);
    req = 4'b0001;
    do_issue();
    req = '0;
    wait_rsp(5);

    // 5: reset during WAIT, pointer returns to NUM_REQ-1
    mdl_lat = 0;
    set_word(2, 24'h646F67);
    push(2, 24'h646F67);
    req = 4'b0100;
    do_issue();
    req = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    sb.delete();
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) cnt++;
    end
    chk("no_rsp_in_reset", cnt, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    mdl_lat = 3;
    set_word(1, 24'h6D6E08);
    set_word(3, 24'h6D6E09);
    push(1, 24'h6D6E08);
    req = 4'b1010;
    do_issue();
    req = '0;
    wait_rsp(4);

    // 6: watchdog, matcher never answers
    mdl_lat = 0;
    set_word(0, 24'h747770);
`ifdef MATCH_SCHED_TIMEOUT_EN
    e.owner = 0;
    e.word  = 24'h747770;
    e.found = 1'b0;
    e.addr  = '0;
    e.err   = 1'b1;
    sb.push_back(e);
    req = 4'b0001;
    do_issue();
    req = '0;
    wait_rsp(TO + 1);
`else
    push(0, 24'h747770);
    req = 4'b0001;
    do_issue();
    req = '0;
    cnt = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) cnt++;
    end
    chk("no_rsp_1000", cnt, 0);
    chk("busy_stuck", 32'(busy), 1);
    chk("err_const", 32'(rsp_err), 0);
    sb.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
